fifo_page_packetizer: RTL
=========================

Name: fifo_page_packetizer

Overview:
- Downstream consumer of the emulator core's FIFO buffer outputs (nFIFOEN, nFIFOBUFWRCLKEN, FIFOBUFWRADDR, FIFOBUFWRDATA, nFIFOSENDBOOT, nFIFOSENDUSER, FIFOCURRPAGE).
- Collects the bit-serial page writes into an internal 8192x1 bit buffer.
- On a send strobe, emits one framed byte packet over a valid/ready byte stream to the host-link stage: sync, type, page number, payload, XOR checksum.

Parameters:
- BOOT_BYTES, 256, payload length in bytes for a boot-page send (1..1024)
- USER_BYTES, 1024, payload length in bytes for a user-page send (1..1024)
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- MCLK  in  1  48MHz system clock; all logic on rising edge
- nRST  in  1  asynchronous active-low reset
- nFIFOEN  in  1  active-low block enable; high = ignore writes/sends, abort frame
- nFIFOBUFWRCLKEN  in  1  active-low bit write enable, sampled each MCLK
- FIFOBUFWRADDR  in  13  bit address of write
- FIFOBUFWRDATA  in  1  bit value to write
- nFIFOSENDBOOT  in  1  active-low level; falling edge requests boot-page frame
- nFIFOSENDUSER  in  1  active-low level; falling edge requests user-page frame
- FIFOCURRPAGE  in  12  page number, latched at send request
- TXDATA  out  8  frame byte
- TXVALID  out  1  TXDATA valid
- TXREADY  in  1  downstream accepts byte when TXVALID&TXREADY at rising edge
- BUSY  out  1  frame in progress
- OVERRUN  out  1  sticky: send request or buffer write dropped while BUSY
- CLROVR  in  1  synchronous clear of OVERRUN (has priority over a same-cycle set)

Behaviour:
- Reset (async, nRST low): TXDATA=0, TXVALID=0, BUSY=0, OVERRUN=0, state IDLE, edge registers=1. Buffer contents not reset.
- Write: nFIFOEN=0 & nFIFOBUFWRCLKEN=0 & BUSY=0 -> buf[FIFOBUFWRADDR]<=FIFOBUFWRDATA that edge. Write while BUSY: dropped, OVERRUN<=1.
- Edge detect: prev registers of both send lines; request = prev=1 & current=0 & nFIFOEN=0. Both fall same cycle -> boot only. A request while BUSY sets OVERRUN and is ignored.
- Latency: request detected at edge N -> at edge N+1 BUSY=1, TXVALID=1, TXDATA=SYNC_BYTE; type and FIFOCURRPAGE latched at N+1.
- Frame order: SYNC_BYTE; type (8'h01 boot, 8'h02 user); {4'h0,PAGE[11:8]}; PAGE[7:0]; payload bytes 0..L-1 (L=BOOT_BYTES or USER_BYTES); checksum = XOR of all payload bytes (8'h00 if none fetched). Total L+5 bytes.
- Payload byte i = {buf[8i+7],...,buf[8i]} (bit 0 = lowest address).
- States:
  - IDLE
  - HDR (4 header bytes; advance on each handshake)
  - FETCH (read 8 bits, one per cycle, 1-cycle RAM latency, TXVALID=0, 9 cycles)
  - PAY (TXVALID=1 holding byte; on handshake: i==L-1 -> CSUM, else FETCH)
  - CSUM (TXVALID=1; on handshake -> IDLE, BUSY=0, TXVALID=0 next edge).
- TXDATA/TXVALID hold stable while TXVALID=1 & TXREADY=0; TXREADY ignored when TXVALID=0.
- Checksum accumulates as each payload byte is assembled.
- Byte counter 10 bits; no wrap beyond L.
- nFIFOEN high mid-frame: next edge -> IDLE, TXVALID=0, BUSY=0, frame truncated, no checksum.
- nRST mid-frame: same immediately (async), OVERRUN cleared.
- Back-to-back: a request in the same cycle as the final CSUM handshake counts as while BUSY (dropped, OVERRUN=1). A request one cycle later starts a new frame.

Test Plan:
- Write 0x35 pattern (bits 1,0,1,0,1,1,0,0 at addr 0..7) plus zeros elsewhere, page 12'h3C7, pulse nFIFOSENDBOOT, TXREADY=1 -> bytes A5,01,03,C7,35, then 255x00, then checksum 35; 261 bytes; BUSY low after.
- User send with buffer all ones, TXREADY=1 -> 1029 bytes: A5,02,page, 1024xFF, checksum 00; TXVALID 1 cycle after detect.
- TXREADY toggled 1-of-3 cycles during a user frame -> identical byte sequence; TXDATA never changes while TXVALID=1 & TXREADY=0.
- Both send lines fall same cycle -> type byte 01 and payload length BOOT_BYTES; second request mid-frame -> OVERRUN=1, frame unaffected; CLROVR -> OVERRUN=0.
- nFIFOEN raised after 10th payload byte -> TXVALID=0, BUSY=0 next edge; writes with nFIFOEN=1 leave buffer unchanged, verified by next frame.
- nRST pulsed mid-payload -> all outputs 0 immediately; a new request after release produces a full correct frame.

Source files
------------

// File: rtl/fifo_page_packetizer_if.sv
// -----------------------------------------------------------------------------
// fifo_page_packetizer_if
//   Bundles the emulator-core FIFO buffer signals and the outgoing byte stream
//   of the page packetizer.
//
//   FIFO side (driven by the emulator core / environment):
//     nFIFOEN          active-low block enable
//     nFIFOBUFWRCLKEN  active-low bit write enable
//     FIFOBUFWRADDR    13-bit bit address of a write
//     FIFOBUFWRDATA    bit value to write
//     nFIFOSENDBOOT    active-low level, falling edge requests a boot frame
//     nFIFOSENDUSER    active-low level, falling edge requests a user frame
//     FIFOCURRPAGE     page number carried in the frame header
//   Byte stream (to the host-link stage):
//     TXDATA / TXVALID driven by the packetizer, TXREADY by the consumer
//
//   master : environment side (drives FIFO signals and TXREADY)
//   slave  : packetizer side
// -----------------------------------------------------------------------------
interface fifo_page_packetizer_if;
  logic        nFIFOEN;
  logic        nFIFOBUFWRCLKEN;
  logic [12:0] FIFOBUFWRADDR;
  logic        FIFOBUFWRDATA;
  logic        nFIFOSENDBOOT;
  logic        nFIFOSENDUSER;
  logic [11:0] FIFOCURRPAGE;
  logic [7:0]  TXDATA;
  logic        TXVALID;
  logic        TXREADY;

  modport master (
    output nFIFOEN,
    output nFIFOBUFWRCLKEN,
    output FIFOBUFWRADDR,
    output FIFOBUFWRDATA,
    output nFIFOSENDBOOT,
    output nFIFOSENDUSER,
    output FIFOCURRPAGE,
    input  TXDATA,
    input  TXVALID,
    output TXREADY
  );

  modport slave (
    input  nFIFOEN,
    input  nFIFOBUFWRCLKEN,
    input  FIFOBUFWRADDR,
    input  FIFOBUFWRDATA,
    input  nFIFOSENDBOOT,
    input  nFIFOSENDUSER,
    input  FIFOCURRPAGE,
    output TXDATA,
    output TXVALID,
    input  TXREADY
  );
endinterface

// File: rtl/fifo_page_packetizer.sv
// -----------------------------------------------------------------------------
// fifo_page_packetizer
//   Collects the emulator core's bit-serial FIFO page writes into an 8192x1
//   buffer and, on a send request, streams one framed packet:
//     SYNC_BYTE, type (01 boot / 02 user), {4'h0,page[11:8]}, page[7:0],
//     L payload bytes, XOR checksum of the payload.
//
//   Ports:
//     MCLK     system clock, rising edge
//     nRST     asynchronous active-low reset
//     bus      fifo_page_packetizer_if.slave (FIFO inputs + TX byte stream)
//     CLROVR   synchronous clear of OVERRUN, wins over a same-cycle set
//     BUSY     frame in progress
//     OVERRUN  sticky: request or write dropped while BUSY
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | no frame; buffer writable; waits for a registered send request
//   HDR    | presenting the four header bytes, one per handshake
//   FETCH  | reading 8 buffer bits for the next payload byte (9 cycles)
//   PAY    | presenting an assembled payload byte
//   CSUM   | presenting the checksum byte
// -----------------------------------------------------------------------------
module fifo_page_packetizer #(
  parameter int         BOOT_BYTES = 256,
  parameter int         USER_BYTES = 1024,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                   MCLK,
  input  logic                   nRST,
  fifo_page_packetizer_if.slave  bus,
  input  logic                   CLROVR,
  output logic                   BUSY,
  output logic                   OVERRUN
);

  localparam logic [9:0] BOOT_LM1 = 10'(BOOT_BYTES - 1);
  localparam logic [9:0] USER_LM1 = 10'(USER_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_PAY,
    S_CSUM
  } state_t;

  state_t      r_state;
  logic [1:0]  r_hdr_idx;
  logic [3:0]  r_bit_idx;
  logic [9:0]  r_byte_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_csum;
  logic        r_type_boot;
  logic [11:0] r_page;
  logic [9:0]  r_len_m1;
  logic [7:0]  r_txdata;
  logic        r_txvalid;

  state_t      w_state_nxt;
  logic [1:0]  w_hdr_idx_nxt;
  logic [3:0]  w_bit_idx_nxt;
  logic [9:0]  w_byte_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_csum_nxt;
  logic        w_type_boot_nxt;
  logic [11:0] w_page_nxt;
  logic [9:0]  w_len_m1_nxt;
  logic [7:0]  w_txdata_nxt;
  logic        w_txvalid_nxt;

  logic        r_boot_prev;
  logic        r_user_prev;
  logic        r_req_boot;
  logic        r_req_user;
  logic        r_overrun;

  logic        r_buf [0:8191];
  logic        r_rd_bit;

  logic        w_busy;
  logic        w_hs;
  logic        w_req_boot;
  logic        w_req_user;
  logic        w_wr_try;
  logic        w_wr_en;
  logic [12:0] w_rd_addr;
  logic [7:0]  w_byte_asm;

  assign w_busy = (r_state != S_IDLE);
  assign w_hs   = r_txvalid & bus.TXREADY;

  // Boot wins when both send lines fall together.
  assign w_req_boot = r_boot_prev & ~bus.nFIFOSENDBOOT & ~bus.nFIFOEN;
  assign w_req_user = r_user_prev & ~bus.nFIFOSENDUSER & ~bus.nFIFOEN & ~w_req_boot;

  assign w_wr_try = ~bus.nFIFOEN & ~bus.nFIFOBUFWRCLKEN;
  assign w_wr_en  = w_wr_try & ~w_busy;

  assign w_rd_addr = {r_byte_idx, r_bit_idx[2:0]};

  // r_rd_bit holds the bit addressed in the previous cycle; on the last
  // fetch cycle it is bit 7 and r_shift[7:1] already holds bits 6..0.
  assign w_byte_asm = {r_rd_bit, r_shift[7:1]};

  // Bit buffer: synchronous write, registered read. Writes and fetches never
  // overlap because writes are only accepted while idle.
  always_ff @(posedge MCLK) begin
    if (w_wr_en) begin
      r_buf[bus.FIFOBUFWRADDR] <= bus.FIFOBUFWRDATA;
    end
    r_rd_bit <= r_buf[w_rd_addr];
  end

  // Send-line edge detection, request pipeline and sticky overrun.
  // A detected request is registered first; the frame starts one edge later.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_boot_prev <= 1'b1;
      r_user_prev <= 1'b1;
      r_req_boot  <= 1'b0;
      r_req_user  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_boot_prev <= bus.nFIFOSENDBOOT;
      r_user_prev <= bus.nFIFOSENDUSER;
      r_req_boot  <= w_req_boot & ~w_busy;
      r_req_user  <= w_req_user & ~w_busy;
      if (CLROVR) begin
        r_overrun <= 1'b0;
      end else if (w_busy && (w_req_boot || w_req_user || w_wr_try)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_hdr_idx   <= 2'd0;
      r_bit_idx   <= 4'd0;
      r_byte_idx  <= 10'd0;
      r_shift     <= 8'h00;
      r_csum      <= 8'h00;
      r_type_boot <= 1'b0;
      r_page      <= 12'h000;
      r_len_m1    <= 10'd0;
      r_txdata    <= 8'h00;
      r_txvalid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hdr_idx   <= w_hdr_idx_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_csum      <= w_csum_nxt;
      r_type_boot <= w_type_boot_nxt;
      r_page      <= w_page_nxt;
      r_len_m1    <= w_len_m1_nxt;
      r_txdata    <= w_txdata_nxt;
      r_txvalid   <= w_txvalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_hdr_idx_nxt   = r_hdr_idx;
    w_bit_idx_nxt   = r_bit_idx;
    w_byte_idx_nxt  = r_byte_idx;
    w_shift_nxt     = r_shift;
    w_csum_nxt      = r_csum;
    w_type_boot_nxt = r_type_boot;
    w_page_nxt      = r_page;
    w_len_m1_nxt    = r_len_m1;
    w_txdata_nxt    = r_txdata;
    w_txvalid_nxt   = r_txvalid;

    if (bus.nFIFOEN && (r_state != S_IDLE)) begin
      // Block disabled mid-frame: truncate without checksum.
      w_state_nxt   = S_IDLE;
      w_txvalid_nxt = 1'b0;
      w_txdata_nxt  = 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_req_boot || r_req_user) && !bus.nFIFOEN) begin
            w_state_nxt     = S_HDR;
            w_hdr_idx_nxt   = 2'd0;
            w_type_boot_nxt = r_req_boot;
            w_page_nxt      = bus.FIFOCURRPAGE;
            w_len_m1_nxt    = r_req_boot ? BOOT_LM1 : USER_LM1;
            w_csum_nxt      = 8'h00;
            w_txdata_nxt    = SYNC_BYTE;
            w_txvalid_nxt   = 1'b1;
          end
        end

        S_HDR: begin
          if (w_hs) begin
            w_hdr_idx_nxt = r_hdr_idx + 2'd1;
            case (r_hdr_idx)
              2'd0:    w_txdata_nxt = r_type_boot ? 8'h01 : 8'h02;
              2'd1:    w_txdata_nxt = {4'h0, r_page[11:8]};
              2'd2:    w_txdata_nxt = r_page[7:0];
              default: begin
                w_state_nxt    = S_FETCH;
                w_txvalid_nxt  = 1'b0;
                w_byte_idx_nxt = 10'd0;
                w_bit_idx_nxt  = 4'd0;
              end
            endcase
          end
        end

        S_FETCH: begin
          w_shift_nxt   = w_byte_asm;
          w_bit_idx_nxt = r_bit_idx + 4'd1;
          if (r_bit_idx == 4'd8) begin
            w_state_nxt   = S_PAY;
            w_bit_idx_nxt = 4'd0;
            w_txdata_nxt  = w_byte_asm;
            w_txvalid_nxt = 1'b1;
            w_csum_nxt    = r_csum ^ w_byte_asm;
          end
        end

        S_PAY: begin
          if (w_hs) begin
            if (r_byte_idx == r_len_m1) begin
              w_state_nxt  = S_CSUM;
              w_txdata_nxt = r_csum;
            end else begin
              w_state_nxt    = S_FETCH;
              w_txvalid_nxt  = 1'b0;
              w_byte_idx_nxt = r_byte_idx + 10'd1;
              w_bit_idx_nxt  = 4'd0;
            end
          end
        end

        S_CSUM: begin
          if (w_hs) begin
            w_state_nxt   = S_IDLE;
            w_txvalid_nxt = 1'b0;
            w_txdata_nxt  = 8'h00;
          end
        end

        default: begin
          w_state_nxt   = S_IDLE;
          w_txvalid_nxt = 1'b0;
          w_txdata_nxt  = 8'h00;
        end
      endcase
    end
  end

  assign bus.TXDATA  = r_txdata;
  assign bus.TXVALID = r_txvalid;
  assign BUSY        = w_busy;
  assign OVERRUN     = r_overrun;

endmodule
